// File: rtl/audio_dac_i2s_tx.sv
// Stereo I2S transmitter: buffers left/right sample pairs in a small FIFO and
// serializes them MSB-first on DACDAT, timed by the codec-mastered BCLK/DACLRCK.
module audio_dac_i2s_tx #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                                 clk_clk,
  input  logic                                 reset_reset_n,
  input  logic [DATA_WIDTH-1:0]                s_left,
  input  logic [DATA_WIDTH-1:0]                s_right,
  input  logic                                 s_valid,
  output logic                                 s_ready,
  input  logic                                 bclk,
  input  logic                                 daclrck,
  output logic                                 dacdat,
  output logic                                 underrun,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]      fifo_level
);

  localparam int unsigned LW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(DATA_WIDTH + 1);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] left;
    logic [DATA_WIDTH-1:0] right;
  } pair_t;

  typedef enum logic {IDLE, RUN} state_t;

  logic bclk_s1, bclk_s2, bclk_d;
  logic lrck_s1, lrck_s2, lrck_prev;
  logic bit_event, lrck_fall, lrck_rise;

  pair_t         mem [FIFO_DEPTH];
  pair_t         head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level_q, level_d;
  logic          push, pop, empty;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic [CW-1:0]         bitcnt_q, bitcnt_d;
  logic                  dacdat_d, underrun_d;

  // Pin synchronizers; lrck_prev holds the LRCK level seen at the previous bit event
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      bclk_s1   <= 1'b0;
      bclk_s2   <= 1'b0;
      bclk_d    <= 1'b0;
      lrck_s1   <= 1'b0;
      lrck_s2   <= 1'b0;
      lrck_prev <= 1'b0;
    end else begin
      bclk_s1 <= bclk;
      bclk_s2 <= bclk_s1;
      bclk_d  <= bclk_s2;
      lrck_s1 <= daclrck;
      lrck_s2 <= lrck_s1;
      if (bit_event) lrck_prev <= lrck_s2;
    end
  end

  assign bit_event = bclk_d & ~bclk_s2;
  assign lrck_fall = bit_event & lrck_prev & ~lrck_s2;
  assign lrck_rise = bit_event & ~lrck_prev & lrck_s2;

  // Sample-pair FIFO; a pop into an empty FIFO never happens, so a coincident
  // push lands for the following frame
  assign push  = s_valid & s_ready;
  assign empty = (level_q == '0);
  assign head  = mem[rd_ptr];

  always_comb begin
    level_d = level_q;
    if (push && !pop)      level_d = level_q + LW'(1);
    else if (pop && !push) level_d = level_q - LW'(1);
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      mem     <= '{default: '0};
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      s_ready <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= '{left: s_left, right: s_right};
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      level_q <= level_d;
      s_ready <= (level_d != LW'(FIFO_DEPTH));
    end
  end

  assign fifo_level = level_q;

  // Serializer FSM: every bit event first drives the I2S delay/padding zero
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    hold_d     = hold_q;
    bitcnt_d   = bitcnt_q;
    dacdat_d   = dacdat;
    underrun_d = 1'b0;
    pop        = 1'b0;
    if (bit_event) begin
      dacdat_d = 1'b0;
      if (lrck_fall) begin
        state_d  = RUN;
        bitcnt_d = CW'(DATA_WIDTH);
        if (!empty) begin
          pop     = 1'b1;
          shreg_d = head.left;
          hold_d  = head.right;
        end else begin
          shreg_d    = '0;
          hold_d     = '0;
          underrun_d = 1'b1;
        end
      end else begin
        case (state_q)
          IDLE: ;
          RUN: begin
            if (lrck_rise) begin
              shreg_d  = hold_q;
              bitcnt_d = CW'(DATA_WIDTH);
            end else if (bitcnt_q != '0) begin
              dacdat_d = shreg_q[DATA_WIDTH-1];
              shreg_d  = {shreg_q[DATA_WIDTH-2:0], 1'b0};
              bitcnt_d = bitcnt_q - CW'(1);
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      hold_q   <= '0;
      bitcnt_q <= '0;
      dacdat   <= 1'b0;
      underrun <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      hold_q   <= hold_d;
      bitcnt_q <= bitcnt_d;
      dacdat   <= dacdat_d;
      underrun <= underrun_d;
    end
  end

endmodule

// File: tb/tb_audio_dac_i2s_tx.sv
// Bench for audio_dac_i2s_tx: drives BCLK/DACLRCK like the codec and rebuilds
// each 32-bit slot from dacdat sampled on BCLK rising edges.
module tb_audio_dac_i2s_tx;

  localparam int unsigned DW   = 16;
  localparam int unsigned HALF = 4;
  localparam int SLOT = 32;

  logic          clk_clk;
  logic          reset_reset_n;
  logic [DW-1:0] s_left, s_right;
  logic          s_valid, s_ready;
  logic          bclk, daclrck, dacdat, underrun;
  logic [2:0]    fifo_level;

  audio_dac_i2s_tx #(.DATA_WIDTH(16), .FIFO_DEPTH(4)) dut (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .s_left        (s_left),
    .s_right       (s_right),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .bclk          (bclk),
    .daclrck       (daclrck),
    .dacdat        (dacdat),
    .underrun      (underrun),
    .fifo_level    (fifo_level)
  );

  initial clk_clk = 1'b0;
  always #5 clk_clk = ~clk_clk;

  typedef struct {
    logic [DW-1:0] l;
    logic [DW-1:0] r;
    logic [31:0]   slot_l;
    logic [31:0]   slot_r;
  } vec_t;

  typedef struct {
    logic [31:0] l;
    logic [31:0] r;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   checks = 0;
  int   failures = 0;
  int   bitpos = 0;
  int   exp_underruns = 0;
  int   ur_pulses = 0;
  int   ur_cycles = 0;
  logic ur_prev = 1'b0;
  logic seen_high = 1'b0;
  logic m_lr = 1'b0;
  logic m_valid = 1'b0;
  logic m_started = 1'b0;
  logic [31:0] m_sh = '0;
  int   m_n = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, want);
    end
  endtask

  function automatic logic [31:0] slot_of(input logic [DW-1:0] w);
    return {1'b0, w, 15'b0};
  endfunction

  // Underrun pulse counting and dacdat activity, sampled mid-cycle
  always @(negedge clk_clk) begin
    if (underrun) ur_cycles++;
    if (underrun && !ur_prev) ur_pulses++;
    ur_prev = underrun;
    if (dacdat) seen_high = 1'b1;
  end

  // Codec model: each left start consumes one scoreboard entry (or expects silence + underrun)
  always @(posedge bclk) begin
    if (reset_reset_n) begin
      if (daclrck != m_lr) begin
        m_valid = 1'b1;
        m_n     = 0;
        m_sh    = '0;
        if (!daclrck) begin
          m_started = 1'b1;
          if (exp_q.size() != 0) cur = exp_q.pop_front();
          else begin
            cur.l = '0;
            cur.r = '0;
            exp_underruns++;
          end
        end
      end
      m_lr = daclrck;
      m_sh = {m_sh[30:0], dacdat};
      m_n++;
      if (m_valid && m_n == SLOT) begin
        if (!m_started)  check("idle_slot", m_sh, 32'd0);
        else if (m_lr)   check("right_slot", m_sh, cur.r);
        else             check("left_slot", m_sh, cur.l);
        m_valid = 1'b0;
      end
    end
  end

  task automatic run_bits(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_clk);
      bclk    = 1'b0;
      daclrck = (bitpos >= 32);
      bitpos  = (bitpos + 1) % 64;
      repeat (HALF) @(negedge clk_clk);
      bclk = 1'b1;
      repeat (HALF - 1) @(negedge clk_clk);
    end
  endtask

  task automatic push_pair(input logic [DW-1:0] l, input logic [DW-1:0] r,
                           input logic [31:0] el, input logic [31:0] er);
    exp_t e;
    int   t;
    @(negedge clk_clk);
    s_left  = l;
    s_right = r;
    s_valid = 1'b1;
    t = 0;
    while (!s_ready && t < 50) begin
      @(negedge clk_clk);
      t++;
    end
    check("push_ready", 32'(s_ready), 32'd1);
    if (s_ready) begin
      e.l = el;
      e.r = er;
      exp_q.push_back(e);
    end
    @(negedge clk_clk);
    s_valid = 1'b0;
  endtask

  task automatic assert_reset();
    reset_reset_n = 1'b0;
    exp_q.delete();
    m_valid   = 1'b0;
    m_started = 1'b0;
    m_lr      = 1'b0;
    cur.l     = '0;
    cur.r     = '0;
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[4];
    int   t;
    tbl[0] = '{16'hA5C3, 16'h1234, 32'h52E1_8000, 32'h091A_0000};
    tbl[1] = '{16'hFFFF, 16'h0001, 32'h7FFF_8000, 32'h0000_8000};
    tbl[2] = '{16'h8000, 16'h7FFF, 32'h4000_0000, 32'h3FFF_8000};
    tbl[3] = '{16'h0000, 16'hFFFF, 32'h0000_0000, 32'h7FFF_8000};

    // Reset values under random input activity
    s_valid = 1'b0; s_left = '0; s_right = '0; bclk = 1'b1; daclrck = 1'b0;
    assert_reset();
    repeat (8) begin
      @(negedge clk_clk);
      s_left  = DW'($urandom);
      s_right = DW'($urandom);
      s_valid = 1'($urandom);
      bclk    = 1'($urandom);
      daclrck = 1'($urandom);
    end
    check("rst_dacdat", 32'(dacdat), 32'd0);
    check("rst_underrun", 32'(underrun), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_ready", 32'(s_ready), 32'd0);
    @(negedge clk_clk);
    s_valid = 1'b0; bclk = 1'b1; daclrck = 1'b0;
    repeat (4) @(negedge clk_clk);
    reset_reset_n = 1'b1;
    @(negedge clk_clk);
    check("rel_ready", 32'(s_ready), 32'd1);

    // Three frames with nothing queued
    seen_high = 1'b0;
    bitpos = 56;
    run_bits(200);
    check("ur_pulses", 32'(ur_pulses), 32'd3);
    check("ur_width", 32'(ur_cycles), 32'd3);
    check("ur_model", 32'(ur_pulses), 32'(exp_underruns));
    check("ur_silent", 32'(seen_high), 32'd0);

    // One pair per frame from the vector table
    for (int i = 0; i < 4; i++) begin
      push_pair(tbl[i].l, tbl[i].r, tbl[i].slot_l, tbl[i].slot_r);
      check("vec_level_push", 32'(fifo_level), 32'd1);
      run_bits(64);
      check("vec_level_frame", 32'(fifo_level), 32'd0);
      check("vec_no_underrun", 32'(ur_pulses), 32'd3);
    end

    // Backpressure: fill, hold a fifth pair, release it with one left start
    for (int i = 0; i < 4; i++) push_pair(tbl[i].l, tbl[i].r, tbl[i].slot_l, tbl[i].slot_r);
    check("bp_full_level", 32'(fifo_level), 32'd4);
    check("bp_full_ready", 32'(s_ready), 32'd0);
    @(negedge clk_clk);
    s_left = 16'hC0DE; s_right = 16'hBEEF; s_valid = 1'b1;
    repeat (5) @(negedge clk_clk);
    check("bp_held_level", 32'(fifo_level), 32'd4);
    check("bp_held_ready", 32'(s_ready), 32'd0);
    fork
      run_bits(64 * 6);
      begin
        exp_t e;
        t = 0;
        while (!s_ready && t < 200) begin
          @(negedge clk_clk);
          t++;
        end
        check("bp_pop_ready", 32'(s_ready), 32'd1);
        check("bp_pop_level", 32'(fifo_level), 32'd3);
        if (s_ready) begin
          e.l = slot_of(16'hC0DE);
          e.r = slot_of(16'hBEEF);
          exp_q.push_back(e);
        end
        @(negedge clk_clk);
        s_valid = 1'b0;
        check("bp_refill_level", 32'(fifo_level), 32'd4);
      end
    join
    check("bp_drained", 32'(fifo_level), 32'd0);
    check("bp_underruns", 32'(ur_pulses), 32'd4);

    // Release reset mid right slot: silent until the first LRCK fall
    @(negedge clk_clk);
    assert_reset();
    bclk = 1'b1; daclrck = 1'b1; bitpos = 40;
    repeat (4) @(negedge clk_clk);
    reset_reset_n = 1'b1;
    push_pair(16'h5A5A, 16'h0F0F, slot_of(16'h5A5A), slot_of(16'h0F0F));
    seen_high = 1'b0;
    run_bits(24);
    check("align_quiet", 32'(seen_high), 32'd0);
    check("align_level", 32'(fifo_level), 32'd1);
    check("align_no_underrun", 32'(ur_pulses), 32'd4);
    run_bits(128);
    check("align_underrun", 32'(ur_pulses), 32'd5);
    check("align_level_end", 32'(fifo_level), 32'd0);

    // Reset in the middle of a left word
    push_pair(16'hF800, 16'h1111, slot_of(16'hF800), slot_of(16'h1111));
    push_pair(16'h3C3C, 16'h2222, slot_of(16'h3C3C), slot_of(16'h2222));
    run_bits(6);
    check("mid_dacdat", 32'(dacdat), 32'd1);
    check("mid_level", 32'(fifo_level), 32'd1);
    #2;
    assert_reset();
    #1;
    check("mid_rst_dacdat", 32'(dacdat), 32'd0);
    check("mid_rst_level", 32'(fifo_level), 32'd0);
    check("mid_rst_ready", 32'(s_ready), 32'd0);
    repeat (3) @(negedge clk_clk);
    reset_reset_n = 1'b1;
    push_pair(16'h6B2D, 16'hD4E1, slot_of(16'h6B2D), slot_of(16'hD4E1));
    run_bits(122);
    check("resume_level", 32'(fifo_level), 32'd0);
    check("resume_underruns", 32'(ur_pulses), 32'd5);

    check("final_ur_model", 32'(ur_pulses), 32'(exp_underruns));
    check("final_ur_width", 32'(ur_cycles), 32'(ur_pulses));
    check("final_queue", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
